// File: rtl/nmi_mbox_pkg.sv
// nmi_mbox_pkg: shared constants for the NMI word mailbox.
// Register offsets, STATUS/CTRL bit positions and the bus FSM states.
package nmi_mbox_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_UDF   = 5;
  localparam int ST_TX_CNT   = 8;
  localparam int ST_RX_CNT   = 16;

  localparam int CTRL_TX_EN      = 0;
  localparam int CTRL_TX_CLR     = 1;
  localparam int CTRL_RX_CLR     = 2;
  localparam int CTRL_IRQ_RX_EN  = 4;
  localparam int CTRL_IRQ_ERR_EN = 5;

  typedef enum logic {
    S_IDLE,
    S_RESP
  } bus_state_t;

endpackage

// File: rtl/nmi_mbox_slv_fifo.sv
// mbox_fifo: first-word-fall-through FIFO with clear.
// Clear beats a same-cycle push; head reads 0 while empty.
module mbox_fifo #(
  parameter  int DEPTH = 8,
  parameter  int W     = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  input  logic          clr,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] cnt
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = empty ? '0 : mem[rptr];

  // Storage array, written at the tail on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

  // Pointer and occupancy tracking; pointers wrap at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/nmi_mbox_slv.sv
// nmi_mbox_slv: NMI-bus slave with TX/RX word FIFOs to stream ports.
// NMI_MBOX_IRQ_EN adds the irq output and CTRL irq enable bits.
module nmi_mbox_slv #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              nmi_valid,
  input  logic [31:0]       nmi_addr,
  input  logic [DATA_W-1:0] nmi_wdata,
  input  logic [3:0]        nmi_wstrb,
  output logic [DATA_W-1:0] nmi_rdata,
  output logic              nmi_ready,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_ready
`ifdef NMI_MBOX_IRQ_EN
  ,
  output logic              irq
`endif
);

  import nmi_mbox_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  bus_state_t        state;
  logic              acc;
  logic              we;
  logic [1:0]        sel;
  logic [DATA_W-1:0] wmask;
  logic [DATA_W-1:0] rd_word;
  logic              tx_push;
  logic              tx_pop;
  logic              tx_clr;
  logic              tx_full;
  logic              tx_empty;
  logic [CW-1:0]     tx_cnt;
  logic              rx_push;
  logic              rx_pop;
  logic              rx_clr;
  logic              rx_full;
  logic              rx_empty;
  logic [CW-1:0]     rx_cnt;
  logic [DATA_W-1:0] rx_head;
  logic              st_wr;
  logic              ctl_wr;
  logic              tx_en;
  logic              tx_ovf;
  logic              rx_udf;
  logic              unused_addr;

  assign unused_addr = ^{nmi_addr[31:4], nmi_addr[1:0]};

  assign acc = (state == S_IDLE) & nmi_valid;
  assign we  = |nmi_wstrb;
  assign sel = nmi_addr[3:2];

  assign tx_push = acc & we & (sel == REG_TXDATA);
  assign rx_pop  = acc & ~we & (sel == REG_RXDATA);
  assign st_wr   = acc & we & (sel == REG_STATUS) & nmi_wstrb[0];
  assign ctl_wr  = acc & we & (sel == REG_CTRL) & nmi_wstrb[0];
  assign tx_clr  = ctl_wr & nmi_wdata[CTRL_TX_CLR];
  assign rx_clr  = ctl_wr & nmi_wdata[CTRL_RX_CLR];

  assign tx_valid = tx_en & ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_ready = ~rx_full;
  assign rx_push  = rx_valid & rx_ready;

  // Disabled byte lanes of a TXDATA write are pushed as zero.
  always_comb begin
    wmask = '0;
    for (int i = 0; i < 4; i++)
      wmask[8*i +: 8] = nmi_wdata[8*i +: 8] & {8{nmi_wstrb[i]}};
  end

  mbox_fifo #(.DEPTH(DEPTH), .W(DATA_W)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .wdata (wmask),
    .pop   (tx_pop),
    .clr   (tx_clr),
    .rdata (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .cnt   (tx_cnt)
  );

  mbox_fifo #(.DEPTH(DEPTH), .W(DATA_W)) u_rx (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .wdata (rx_data),
    .pop   (rx_pop),
    .clr   (rx_clr),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .cnt   (rx_cnt)
  );

`ifdef NMI_MBOX_IRQ_EN
  logic irq_rx_en;
  logic irq_err_en;

  // Interrupt enables and the registered level interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_rx_en  <= 1'b0;
      irq_err_en <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (ctl_wr) begin
        irq_rx_en  <= nmi_wdata[CTRL_IRQ_RX_EN];
        irq_err_en <= nmi_wdata[CTRL_IRQ_ERR_EN];
      end
      irq <= (irq_rx_en & ~rx_empty) |
             (irq_err_en & (tx_ovf | rx_udf));
    end
  end
`endif

  // Read mux; STATUS shows the state as seen at the accept edge.
  always_comb begin
    rd_word = '0;
    unique case (sel)
      REG_TXDATA: rd_word = '0;
      REG_RXDATA: rd_word = rx_head;
      REG_STATUS: begin
        rd_word[ST_TX_FULL]       = tx_full;
        rd_word[ST_TX_EMPTY]      = tx_empty;
        rd_word[ST_RX_FULL]       = rx_full;
        rd_word[ST_RX_EMPTY]      = rx_empty;
        rd_word[ST_TX_OVF]        = tx_ovf;
        rd_word[ST_RX_UDF]        = rx_udf;
        rd_word[ST_TX_CNT +: 8]   = 8'(tx_cnt);
        rd_word[ST_RX_CNT +: 8]   = 8'(rx_cnt);
      end
      REG_CTRL: begin
        rd_word[CTRL_TX_EN] = tx_en;
`ifdef NMI_MBOX_IRQ_EN
        rd_word[CTRL_IRQ_RX_EN]  = irq_rx_en;
        rd_word[CTRL_IRQ_ERR_EN] = irq_err_en;
`endif
      end
    endcase
  end

  // CTRL enable and sticky error flags; a new error beats W1C.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_en  <= 1'b0;
      tx_ovf <= 1'b0;
      rx_udf <= 1'b0;
    end else begin
      if (ctl_wr) tx_en <= nmi_wdata[CTRL_TX_EN];
      tx_ovf <= (tx_ovf & ~(st_wr & nmi_wdata[ST_TX_OVF])) |
                (tx_push & tx_full);
      rx_udf <= (rx_udf & ~(st_wr & nmi_wdata[ST_RX_UDF])) |
                (rx_pop & rx_empty);
    end
  end

  // Bus FSM: accept in IDLE, one-cycle ready pulse in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      nmi_ready <= 1'b0;
      nmi_rdata <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (nmi_valid) begin
            state     <= S_RESP;
            nmi_ready <= 1'b1;
            nmi_rdata <= we ? '0 : rd_word;
          end
        end
        S_RESP: begin
          state     <= S_IDLE;
          nmi_ready <= 1'b0;
          nmi_rdata <= '0;
        end
      endcase
    end
  end

endmodule
